input_debouncer: RTL and testbench

//  Conditions the raw board switches and push-keys before they reach the superio register file.
//  Per bit: 2-FF synchroniser, then a tick-based stability counter.

---
 rtl/superio_pkg.sv | 10 +
 rtl/debounce_chan.sv | 60 ++++++
 rtl/input_debouncer.sv | 68 ++++++
 tb/tb_input_debouncer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/superio_pkg.sv
// rtl/superio_pkg.sv - shared superio constants for switch/key conditioning
package superio_pkg;

    localparam int          DEBOUNCE_TICK_DIV = 50000;
    localparam int          DEBOUNCE_STABLE   = 8;
    localparam logic [7:0]  SW_KEY_RST_VAL    = 8'h0F;
    localparam int          SW_LSB            = 4;
    localparam int          KEY_LSB           = 0;

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one-bit synchroniser plus tick-based stability counter
module debounce_chan #(
    parameter int   STABLE_TICKS = 8,
    parameter logic RST_BIT      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall,
    output logic upd
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff = (r_s2 != r_db);
    assign w_done = w_diff && tick && (r_cnt == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= RST_BIT;
            r_s2   <= RST_BIT;
            r_db   <= RST_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_rise <= w_done && r_s2;
            r_fall <= w_done && !r_s2;
            // Any agreement with the current level restarts the count, tick or not.
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else if (tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db   = r_db;
    assign rise = r_rise;
    assign fall = r_fall;
    assign upd  = w_done;

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - debounced switch/key levels with edge pulses, sticky events and IRQ
module input_debouncer
    import superio_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = DEBOUNCE_TICK_DIV,
    parameter int               STABLE_TICKS = DEBOUNCE_STABLE,
    parameter logic [WIDTH-1:0] RST_VAL      = WIDTH'(SW_KEY_RST_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt_pend,
    input  logic [WIDTH-1:0] evt_clr,
    output logic             evt_irq
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] r_pend;

    assign w_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .RST_BIT      (RST_VAL[g])
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_in[g]),
            .tick (w_tick),
            .db   (db_out[g]),
            .rise (rise[g]),
            .fall (fall[g]),
            .upd  (w_upd[g])
        );
    end

    // Set from the update strobe so the flag lands with the new level; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~evt_clr) | w_upd;
        end
    end

    assign evt_pend = r_pend;
    assign evt_irq  = |r_pend;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw_in;
    logic [7:0] db_out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] evt_pend;
    logic [7:0] evt_clr;
    logic       evt_irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n;

    input_debouncer #(
        .WIDTH        (8),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .RST_VAL      (8'h0F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_in   (raw_in),
        .db_out   (db_out),
        .rise     (rise),
        .fall     (fall),
        .evt_pend (evt_pend),
        .evt_clr  (evt_clr),
        .evt_irq  (evt_irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // 1: reset with raw held at A5
        rst = 1'b1; raw_in = 8'hA5; evt_clr = 8'h00;
        step(); step();
        chk("rst_db",   db_out,   8'h0F);
        chk("rst_rise", rise,     8'h00);
        chk("rst_fall", fall,     8'h00);
        chk("rst_pend", evt_pend, 8'h00);
        chk("rst_irq",  {7'd0, evt_irq}, 8'h00);
        rst = 1'b0; raw_in = 8'h0F; cyc = 0;

        // 2: switch bit4 rises, latency window 11..14
        raw_in = 8'h1F; n = 0;
        while (n < 20 && db_out !== 8'h1F) begin step(); n++; end
        chk("t2_latency_ok", {7'd0, (n >= 11 && n <= 14)}, 8'h01);
        chk("t2_db",   db_out,   8'h1F);
        chk("t2_rise", rise,     8'h10);
        chk("t2_fall", fall,     8'h00);
        chk("t2_pend", evt_pend, 8'h10);
        chk("t2_irq",  {7'd0, evt_irq}, 8'h01);
        step();
        chk("t2_rise_gone", rise,   8'h00);
        chk("t2_db_hold",   db_out, 8'h1F);

        // 3: six-clock glitch on key bit0 must be rejected
        for (int i = 0; i < 26; i++) begin
            raw_in = (i < 6) ? 8'h1E : 8'h1F;
            step();
            chk("t3_db",   db_out, 8'h1F);
            chk("t3_fall", fall,   8'h00);
        end
        chk("t3_pend", evt_pend, 8'h10);

        // 4: clear coincident with a new fall on bit4; set wins
        while (cyc % 4 != 0) step();
        raw_in = 8'h0F;
        repeat (11) step();
        chk("t4_db_pre",   db_out, 8'h1F);
        chk("t4_fall_pre", fall,   8'h00);
        evt_clr = 8'h10;
        step();
        evt_clr = 8'h00;
        chk("t4_db",   db_out,   8'h0F);
        chk("t4_fall", fall,     8'h10);
        chk("t4_pend", evt_pend, 8'h10);
        chk("t4_irq",  {7'd0, evt_irq}, 8'h01);
        step();
        chk("t4_fall_gone", fall,     8'h00);
        chk("t4_pend_hold", evt_pend, 8'h10);
        evt_clr = 8'h10;
        step();
        evt_clr = 8'h00;
        chk("t4_pend_clr", evt_pend, 8'h00);
        chk("t4_irq_clr",  {7'd0, evt_irq}, 8'h00);

        // 5: reset after the 2nd qualifying tick of a bit7 change
        while (cyc % 4 != 0) step();
        raw_in = 8'h8F;
        repeat (8) step();
        chk("t5_db_pending", db_out, 8'h0F);
        rst = 1'b1;
        step();
        rst = 1'b0; cyc = 0;
        chk("t5_rst_db",   db_out,   8'h0F);
        chk("t5_rst_rise", rise,     8'h00);
        chk("t5_rst_pend", evt_pend, 8'h00);
        for (int i = 1; i <= 11; i++) begin
            step();
            chk("t5_db_wait",   db_out, 8'h0F);
            chk("t5_rise_wait", rise,   8'h00);
        end
        step();
        chk("t5_db",   db_out,   8'h8F);
        chk("t5_rise", rise,     8'h80);
        chk("t5_pend", evt_pend, 8'h80);

        // 6: all bits flip together
        rst = 1'b1; raw_in = 8'h0F;
        step();
        rst = 1'b0; cyc = 0;
        chk("t6_rst_db", db_out, 8'h0F);
        raw_in = 8'hF0; n = 0;
        while (n < 20 && db_out === 8'h0F) begin step(); n++; end
        chk("t6_latency", 8'(n), 8'd12);
        chk("t6_db",   db_out,   8'hF0);
        chk("t6_rise", rise,     8'hF0);
        chk("t6_fall", fall,     8'h0F);
        chk("t6_pend", evt_pend, 8'hFF);
        chk("t6_irq",  {7'd0, evt_irq}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
